// File: rtl/imm_fetch_pkg.sv
// Shared definitions for the wasm fetch/decode front stage: FSM states, opcodes,
// trap codes and LEB128 length limits.
package imm_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DECODE = 2'd2
    } state_t;

    localparam logic [7:0] OP_I32_CONST = 8'h41;
    localparam logic [7:0] OP_I64_CONST = 8'h42;
    localparam logic [7:0] OP_F32_CONST = 8'h43;
    localparam logic [7:0] OP_F64_CONST = 8'h44;

    localparam logic [3:0] TRAP_NONE = 4'd0;
    localparam logic [3:0] TRAP_MEM  = 4'd1;
    localparam logic [3:0] TRAP_LEB  = 4'd2;

    localparam int LEB_MAX_I32 = 5;
    localparam int LEB_MAX_I64 = 10;
    localparam int LEB_BYTES   = 10;

endpackage

// File: rtl/imm_fetch_leb128.sv
// Combinational signed LEB128 decoder over up to ten bytes (byte 0 in bits [7:0]).
// Reports encoded length and flags an encoding still continuing at its size limit.
module leb128_decode
    import imm_fetch_pkg::*;
(
    input  logic [8*LEB_BYTES-1:0] leb_bytes,
    input  logic                   is64,
    output logic [63:0]            value,
    output logic [3:0]             len,
    output logic                   overlong
);

    localparam int ACC_W = 7 * LEB_BYTES;

    logic [ACC_W-1:0]        acc;
    logic signed [ACC_W-1:0] sx;
    logic                    found;
    int                      max_len;
    int                      shift;

    always_comb begin
        max_len = is64 ? LEB_MAX_I64 : LEB_MAX_I32;
        acc     = '0;
        found   = 1'b0;
        len     = '0;
        for (int i = 0; i < LEB_BYTES; i++) begin
            if (!found && i < max_len) begin
                acc = acc | ({{(ACC_W-7){1'b0}}, leb_bytes[8*i +: 7]} << (7*i));
                if (!leb_bytes[8*i+7]) begin
                    found = 1'b1;
                    len   = 4'(i + 1);
                end
            end
        end
        overlong = !found;
        // Left-align the last payload bit, then arithmetic shift back to sign-extend.
        shift    = ACC_W - 7 * int'(len);
        sx       = $signed(acc << shift) >>> shift;
        value    = overlong ? 64'd0 : sx[63:0];
    end

    logic unused_sx_hi;
    assign unused_sx_hi = ^sx[ACC_W-1:64];

endmodule

// File: rtl/imm_fetch.sv
// Fetch/decode front stage: reads one genrom window at pc, decodes opcode and
// immediate, and presents {opcode, imm, next_pc, trap} with a one-cycle valid.
module imm_fetch
    import imm_fetch_pkg::*;
#(
    parameter int MEM_DEPTH = 4,
    parameter int MEM_EXTRA = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [MEM_DEPTH:0]            pc,
    output logic [MEM_DEPTH:0]            mem_addr,
    output logic [MEM_EXTRA-1:0]          mem_extra,
    input  logic [(2**MEM_EXTRA)*8-1:0]   mem_data,
    input  logic                          mem_error,
    output logic                          busy,
    output logic                          valid,
    output logic [7:0]                    opcode,
    output logic [63:0]                   imm,
    output logic [MEM_DEPTH:0]            next_pc,
    output logic [3:0]                    trap
);

    localparam int AW         = MEM_DEPTH + 1;
    localparam int WIN_BYTES  = 2**MEM_EXTRA;
    localparam int DATA_W     = WIN_BYTES * 8;
    localparam int USED_BYTES = 1 + LEB_BYTES;

    assign mem_extra = MEM_EXTRA'(WIN_BYTES - 1);

    state_t state_q, state_d;
    logic   accept_p0;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept_p0 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept_p0 = 1'b1;
                    state_d   = ST_READ;
                end
            end
            ST_READ:   state_d = ST_DECODE;
            ST_DECODE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Decode stage: window from genrom is registered and stable in ST_DECODE
    logic [7:0]             win_p1 [USED_BYTES];
    logic [8*LEB_BYTES-1:0] leb_bytes_p1;

    always_comb begin
        leb_bytes_p1 = '0;
        for (int k = 0; k < USED_BYTES; k++) begin
            win_p1[k] = mem_data[DATA_W-1-8*k -: 8];
        end
        for (int k = 0; k < LEB_BYTES; k++) begin
            leb_bytes_p1[8*k +: 8] = win_p1[k+1];
        end
    end

    logic unused_win_tail;
    assign unused_win_tail = ^mem_data[DATA_W-1-8*USED_BYTES:0];

    logic [63:0] leb_value_p1;
    logic [3:0]  leb_len_p1;
    logic        leb_overlong_p1;

    leb128_decode u_leb (
        .leb_bytes (leb_bytes_p1),
        .is64      (win_p1[0] == OP_I64_CONST),
        .value     (leb_value_p1),
        .len       (leb_len_p1),
        .overlong  (leb_overlong_p1)
    );

    logic [7:0]    dec_opcode_p1;
    logic [63:0]   dec_imm_p1;
    logic [3:0]    dec_len_p1;
    logic [3:0]    dec_trap_p1;
    logic [AW-1:0] dec_next_pc_p1;

    always_comb begin
        dec_opcode_p1 = win_p1[0];
        dec_imm_p1    = '0;
        dec_len_p1    = '0;
        dec_trap_p1   = TRAP_NONE;
        case (win_p1[0])
            OP_I32_CONST: begin
                if (leb_overlong_p1) dec_trap_p1 = TRAP_LEB;
                else begin
                    dec_imm_p1 = {32'd0, leb_value_p1[31:0]};
                    dec_len_p1 = leb_len_p1;
                end
            end
            OP_I64_CONST: begin
                if (leb_overlong_p1) dec_trap_p1 = TRAP_LEB;
                else begin
                    dec_imm_p1 = leb_value_p1;
                    dec_len_p1 = leb_len_p1;
                end
            end
            OP_F32_CONST: begin
                dec_imm_p1 = {32'd0, win_p1[4], win_p1[3], win_p1[2], win_p1[1]};
                dec_len_p1 = 4'd4;
            end
            OP_F64_CONST: begin
                dec_imm_p1 = {win_p1[8], win_p1[7], win_p1[6], win_p1[5],
                              win_p1[4], win_p1[3], win_p1[2], win_p1[1]};
                dec_len_p1 = 4'd8;
            end
            default: ;
        endcase
        // A bus error makes the window contents meaningless, so it overrides everything.
        if (mem_error) begin
            dec_opcode_p1 = '0;
            dec_imm_p1    = '0;
            dec_len_p1    = '0;
            dec_trap_p1   = TRAP_MEM;
        end
        if (dec_trap_p1 != TRAP_NONE) dec_next_pc_p1 = mem_addr;
        else dec_next_pc_p1 = mem_addr + AW'(1) + AW'(dec_len_p1);
    end

    // Output stage: results registered at the end of ST_DECODE
    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            valid    <= 1'b0;
            opcode   <= '0;
            imm      <= '0;
            next_pc  <= '0;
            trap     <= TRAP_NONE;
            mem_addr <= '0;
        end else begin
            busy  <= accept_p0 || (state_q != ST_IDLE);
            valid <= (state_q == ST_DECODE);
            if (accept_p0) mem_addr <= pc;
            if (state_q == ST_DECODE) begin
                opcode  <= dec_opcode_p1;
                imm     <= dec_imm_p1;
                next_pc <= dec_next_pc_p1;
                trap    <= dec_trap_p1;
            end
        end
    end

endmodule
